// File: rtl/serdes_if_pkg.sv
// -----------------------------------------------------------------------------
// serdes_if_pkg
// Shared definitions for the serdes RX/TX fabric blocks (serdes_rx_word_align,
// serdes_k7_if).
//   K28_5         : comma byte value
//   link_state_t  : 2-bit link state encoding (LOS=0, ACQ=1, SYNC=2)
//   rx_event_t    : classification of one received 16-bit word
//   comma_pos_t   : byte position of the comma inside the raw word
//   decode_event  : raw word + per-byte flags -> rx_event_t
// -----------------------------------------------------------------------------
package serdes_if_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;

    typedef enum logic [1:0] {
        LINK_LOS  = 2'd0,
        LINK_ACQ  = 2'd1,
        LINK_SYNC = 2'd2
    } link_state_t;

    typedef enum logic [2:0] {
        EV_NONE     = 3'd0,
        EV_ERR      = 3'd1,
        EV_DOUBLE   = 3'd2,
        EV_COMMA_LO = 3'd3,
        EV_COMMA_HI = 3'd4
    } rx_event_t;

    typedef enum logic {
        COMMA_POS_LO = 1'b0,
        COMMA_POS_HI = 1'b1
    } comma_pos_t;

    // A code error anywhere in the word outranks any comma seen in it, so a
    // corrupted word can never advance acquisition.
    function automatic rx_event_t decode_event(
        input logic [15:0] data,
        input logic [1:0]  is_k,
        input logic [1:0]  disp_err,
        input logic [1:0]  not_in_table,
        input logic [7:0]  comma
    );
        logic comma_lo;
        logic comma_hi;
        comma_lo = is_k[0] && (data[7:0]  == comma);
        comma_hi = is_k[1] && (data[15:8] == comma);
        if ((|disp_err) || (|not_in_table)) begin
            return EV_ERR;
        end else if (comma_lo && comma_hi) begin
            return EV_DOUBLE;
        end else if (comma_lo) begin
            return EV_COMMA_LO;
        end else if (comma_hi) begin
            return EV_COMMA_HI;
        end
        return EV_NONE;
    endfunction

endpackage

// File: rtl/serdes_byte_shift.sv
// -----------------------------------------------------------------------------
// serdes_byte_shift
// Two-stage byte realignment: a previous-word register followed by a
// registered sel-controlled mux, for data and K flags together.
//   clk          : RX user clock, rising edge
//   rst_n        : asynchronous active-low reset
//   sel          : 0 = comma in byte 0 of raw word, 1 = comma in byte 1
//   rx_data      : raw 16-bit word, byte 0 earlier in time
//   rx_is_k      : raw per-byte K flags
//   aligned_data : realigned word (comma always in [7:0])
//   aligned_is_k : realigned K flags
// -----------------------------------------------------------------------------
module serdes_byte_shift (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [15:0] rx_data,
    input  logic [1:0]  rx_is_k,
    output logic [15:0] aligned_data,
    output logic [1:0]  aligned_is_k
);

    logic [15:0] prev_data_reg;
    logic [1:0]  prev_is_k_reg;
    logic [15:0] aligned_data_reg;
    logic [1:0]  aligned_is_k_reg;

    // With sel=1 the comma sits in the high byte of the previous word, so the
    // aligned word pairs that byte with the first (earlier) byte of the
    // current word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_data_reg    <= 16'h0000;
            prev_is_k_reg    <= 2'b00;
            aligned_data_reg <= 16'h0000;
            aligned_is_k_reg <= 2'b00;
        end else begin
            prev_data_reg <= rx_data;
            prev_is_k_reg <= rx_is_k;
            if (sel) begin
                aligned_data_reg <= {rx_data[7:0], prev_data_reg[15:8]};
                aligned_is_k_reg <= {rx_is_k[0], prev_is_k_reg[1]};
            end else begin
                aligned_data_reg <= prev_data_reg;
                aligned_is_k_reg <= prev_is_k_reg;
            end
        end
    end

    assign aligned_data = aligned_data_reg;
    assign aligned_is_k = aligned_is_k_reg;

endmodule

// File: rtl/serdes_rx_word_align.sv
// -----------------------------------------------------------------------------
// serdes_rx_word_align
// RX 16-bit word aligner and link monitor between the GTX RX fabric port and
// the serdes_k7_if RX path. Finds the K28.5 comma, realigns so the comma lands
// in byte 0, tracks link state (LOS/ACQ/SYNC) and counts code-error words.
//
// Optional build macro: SERDES_RX_ALIGN_ERR_CNT_EN
//   defined   : O_err_cnt is a saturating count of error words
//   undefined : no counter is built, O_err_cnt is tied to 16'h0000
//
// Ports:
//   I_serdes_rx_clk   : RX user clock, rising edge
//   I_rst_n           : asynchronous active-low reset
//   I_rx_data[15:0]   : raw RX data, byte 0 earlier in time
//   I_rx_char_is_k    : per-byte K flag
//   I_rx_disp_err     : per-byte disparity error
//   I_rx_not_in_table : per-byte invalid-code flag
//   O_rx_data[15:0]   : aligned data
//   O_rx_data_is_k    : aligned K flags
//   O_rx_valid        : aligned word valid (link up, delayed to the data)
//   O_link_up         : link state is SYNC
//   O_align_sel       : 0 comma in byte 0, 1 comma in byte 1 of raw word
//   O_err_cnt[15:0]   : saturating code-error word count
// -----------------------------------------------------------------------------
module serdes_rx_word_align
    import serdes_if_pkg::*;
#(
    parameter logic [7:0] COMMA_CHAR = K28_5,
    parameter int         SYNC_CNT   = 4,
    parameter int         LOSS_CNT   = 4
) (
    input  logic        I_serdes_rx_clk,
    input  logic        I_rst_n,
    input  logic [15:0] I_rx_data,
    input  logic [1:0]  I_rx_char_is_k,
    input  logic [1:0]  I_rx_disp_err,
    input  logic [1:0]  I_rx_not_in_table,
    output logic [15:0] O_rx_data,
    output logic [1:0]  O_rx_data_is_k,
    output logic        O_rx_valid,
    output logic        O_link_up,
    output logic        O_align_sel,
    output logic [15:0] O_err_cnt
);

    localparam logic [3:0] SYNC_CNT_W = 4'(SYNC_CNT);
    localparam logic [3:0] LOSS_CNT_W = 4'(LOSS_CNT);

    link_state_t state_reg;
    comma_pos_t  sel_reg;
    logic [3:0]  good_reg;
    logic [3:0]  bad_reg;
    logic        link_up_reg;
    logic        rx_valid_reg;

    rx_event_t   ev;
    logic        comma_at_sel;
    logic        comma_any;

    always_comb begin
        ev = decode_event(I_rx_data, I_rx_char_is_k, I_rx_disp_err,
                          I_rx_not_in_table, COMMA_CHAR);
        comma_any    = (ev == EV_COMMA_LO) || (ev == EV_COMMA_HI);
        comma_at_sel = (sel_reg == COMMA_POS_HI) ? (ev == EV_COMMA_HI)
                                                 : (ev == EV_COMMA_LO);
    end

    // Link FSM; link_up_reg is updated together with the state so it tracks
    // SYNC with no extra cycle.
    always_ff @(posedge I_serdes_rx_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_reg   <= LINK_LOS;
            sel_reg     <= COMMA_POS_LO;
            good_reg    <= 4'd0;
            bad_reg     <= 4'd0;
            link_up_reg <= 1'b0;
        end else begin
            case (state_reg)
                LINK_LOS: begin
                    if (comma_any) begin
                        sel_reg  <= (ev == EV_COMMA_HI) ? COMMA_POS_HI : COMMA_POS_LO;
                        good_reg <= 4'd1;
                        bad_reg  <= 4'd0;
                        if (SYNC_CNT_W == 4'd1) begin
                            state_reg   <= LINK_SYNC;
                            link_up_reg <= 1'b1;
                        end else begin
                            state_reg <= LINK_ACQ;
                        end
                    end
                end
                LINK_ACQ: begin
                    if (comma_at_sel) begin
                        if (good_reg + 4'd1 == SYNC_CNT_W) begin
                            state_reg   <= LINK_SYNC;
                            link_up_reg <= 1'b1;
                            good_reg    <= 4'd0;
                        end else begin
                            good_reg <= good_reg + 4'd1;
                        end
                    end else if (ev != EV_NONE) begin
                        // wrong-position comma, double comma or code error
                        state_reg <= LINK_LOS;
                        good_reg  <= 4'd0;
                    end
                end
                LINK_SYNC: begin
                    if (comma_at_sel) begin
                        bad_reg <= 4'd0;
                    end else if (ev != EV_NONE) begin
                        if (bad_reg + 4'd1 == LOSS_CNT_W) begin
                            state_reg   <= LINK_LOS;
                            link_up_reg <= 1'b0;
                            bad_reg     <= 4'd0;
                            good_reg    <= 4'd0;
                        end else begin
                            bad_reg <= bad_reg + 4'd1;
                        end
                    end
                end
                default: begin
                    state_reg   <= LINK_LOS;
                    link_up_reg <= 1'b0;
                    good_reg    <= 4'd0;
                    bad_reg     <= 4'd0;
                end
            endcase
        end
    end

    // The aligned word leaves the shifter one cycle after the state decision
    // that covered its comma, so valid follows link_up by one register.
    always_ff @(posedge I_serdes_rx_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rx_valid_reg <= 1'b0;
        end else begin
            rx_valid_reg <= link_up_reg;
        end
    end

    serdes_byte_shift u_byte_shift (
        .clk          (I_serdes_rx_clk),
        .rst_n        (I_rst_n),
        .sel          (sel_reg == COMMA_POS_HI),
        .rx_data      (I_rx_data),
        .rx_is_k      (I_rx_char_is_k),
        .aligned_data (O_rx_data),
        .aligned_is_k (O_rx_data_is_k)
    );

`ifdef SERDES_RX_ALIGN_ERR_CNT_EN
    logic [15:0] err_cnt_reg;

    always_ff @(posedge I_serdes_rx_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            err_cnt_reg <= 16'h0000;
        end else if ((ev == EV_ERR) && (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_reg <= err_cnt_reg + 16'd1;
        end
    end

    assign O_err_cnt = err_cnt_reg;
`else
    assign O_err_cnt = 16'h0000;
`endif

    assign O_link_up   = link_up_reg;
    assign O_rx_valid  = rx_valid_reg;
    assign O_align_sel = sel_reg;

endmodule
